// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter.
//   XLEN       : data width of a register write
//   REG_ADDR_W : width of a register index
//   src_e      : writeback source encoding (SRC_ALU = 0, SRC_MEM = 1)
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic with its priority pointer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointer -> ALU)
//   req_alu_i   : ALU requester valid
//   req_mem_i   : MEM requester valid
//   block_i     : suppress all grants this cycle (pointer holds)
//   gnt_alu_o   : combinational grant to ALU
//   gnt_mem_o   : combinational grant to MEM
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu_i,
  input  logic req_mem_i,
  input  logic block_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  src_e ptr_q;
  src_e ptr_d;
  logic gnt_alu_s;
  logic gnt_mem_s;

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grant selection and pointer update: the winner hands priority to the
  // other requester, even when it was the only one asking.
  always_comb begin
    gnt_alu_s = 1'b0;
    gnt_mem_s = 1'b0;
    ptr_d     = ptr_q;
    if (!block_i) begin
      if (req_alu_i && (!req_mem_i || (ptr_q == SRC_ALU))) begin
        gnt_alu_s = 1'b1;
      end else if (req_mem_i) begin
        gnt_mem_s = 1'b1;
      end else begin
        gnt_alu_s = 1'b0;
      end
    end else begin
      gnt_alu_s = 1'b0;
    end
    if (gnt_alu_s) begin
      ptr_d = SRC_MEM;
    end else if (gnt_mem_s) begin
      ptr_d = SRC_ALU;
    end else begin
      ptr_d = ptr_q;
    end
  end

  assign gnt_alu_o = gnt_alu_s;
  assign gnt_mem_o = gnt_mem_s;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write
// port, with a registered write port (latency 1).
// Optional feature macro: REGARB_BYPASS_EN adds forwarding compare ports.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   alu_valid/alu_rd/alu_data       : ALU writeback request
//   alu_ready                       : ALU request accepted this cycle
//   mem_valid/mem_rd/mem_data       : load writeback request
//   mem_ready                       : load request accepted this cycle
//   flush                           : blocks all acceptances while high
//   rf_we/rf_rd/rf_wdata            : registered register-file write port
//   last_src                        : source of last acceptance (0 ALU, 1 MEM)
//   fwd_rs1/fwd_rs2 (macro only)    : source indices to compare
//   fwdN_hit/fwdN_data (macro only) : in-flight write matches fwd_rsN
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  output logic                  mem_ready,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata,
`ifdef REGARB_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] fwd_rs1,
  input  logic [REG_ADDR_W-1:0] fwd_rs2,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [XLEN-1:0]       fwd1_data,
  output logic [XLEN-1:0]       fwd2_data,
`endif
  output logic                  last_src
);

  logic                  gnt_alu_s;
  logic                  gnt_mem_s;
  logic                  block_s;
  logic                  rf_we_q,    rf_we_d;
  logic [REG_ADDR_W-1:0] rf_rd_q,    rf_rd_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  last_src_q, last_src_d;

  // Readies must be low while reset is asserted, not only after the edge.
  assign block_s = flush | ~rst_n;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_alu_i (alu_valid),
    .req_mem_i (mem_valid),
    .block_i   (block_s),
    .gnt_alu_o (gnt_alu_s),
    .gnt_mem_o (gnt_mem_s)
  );

  assign alu_ready = gnt_alu_s;
  assign mem_ready = gnt_mem_s;

  // Next write-port contents: load the winner, strobe only for rd != 0.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    last_src_d = last_src_q;
    if (gnt_alu_s) begin
      rf_we_d    = (alu_rd != {REG_ADDR_W{1'b0}});
      rf_rd_d    = alu_rd;
      rf_wdata_d = alu_data;
      last_src_d = SRC_ALU;
    end else if (gnt_mem_s) begin
      rf_we_d    = (mem_rd != {REG_ADDR_W{1'b0}});
      rf_rd_d    = mem_rd;
      rf_wdata_d = mem_data;
      last_src_d = SRC_MEM;
    end else begin
      rf_we_d    = 1'b0;
    end
  end

  // Write-port registers; async reset drops any in-flight write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= {REG_ADDR_W{1'b0}};
      rf_wdata_q <= {XLEN{1'b0}};
      last_src_q <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      last_src_q <= last_src_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign last_src = last_src_q;

`ifdef REGARB_BYPASS_EN
  // x0 is never forwarded: it reads as zero regardless of pending writes.
  assign fwd1_hit  = rf_we_q && (rf_rd_q == fwd_rs1) && (fwd_rs1 != {REG_ADDR_W{1'b0}});
  assign fwd2_hit  = rf_we_q && (rf_rd_q == fwd_rs2) && (fwd_rs2 != {REG_ADDR_W{1'b0}});
  assign fwd1_data = fwd1_hit ? rf_wdata_q : {XLEN{1'b0}};
  assign fwd2_data = fwd2_hit ? rf_wdata_q : {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, flush;
  logic [4:0]  alu_rd, mem_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        rf_we, last_src;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
`ifdef REGARB_BYPASS_EN
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_prio;   // 0: ALU preferred, 1: MEM preferred
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_acc_alu, m_acc_mem;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .flush(flush),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
`ifdef REGARB_BYPASS_EN
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .last_src(last_src)
  );

  function automatic void model_reset();
    m_prio = 0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_last = 1'b0;
  endfunction

  // Who should be granted given current inputs and model priority
  function automatic void exp_ready(output logic ea, output logic em);
    if (!rst_n || flush) begin
      ea = 1'b0; em = 1'b0;
    end else if (alu_valid && mem_valid) begin
      ea = (m_prio == 0); em = (m_prio == 1);
    end else begin
      ea = alu_valid; em = mem_valid;
    end
  endfunction

  // Advance one clock and update the model; returns at posedge + 1
  task automatic tick();
    logic ea, em;
    exp_ready(ea, em);
    @(posedge clk);
    m_acc_alu = ea; m_acc_mem = em;
    if (ea) begin
      m_we = (alu_rd != 5'd0); m_rd = alu_rd; m_data = alu_data; m_last = 1'b0; m_prio = 1;
    end else if (em) begin
      m_we = (mem_rd != 5'd0); m_rd = mem_rd; m_data = mem_data; m_last = 1'b1; m_prio = 0;
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; mem_valid = 1'b0; flush = 1'b0;
    alu_rd = 5'd0; mem_rd = 5'd0; alu_data = 32'd0; mem_data = 32'd0;
`ifdef REGARB_BYPASS_EN
    fwd_rs1 = 5'd0; fwd_rs2 = 5'd0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    idle_inputs();
    alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd4; mem_rd = 5'd6;
    @(posedge clk); #2;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
    total++; if (rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rf_rd); end
    total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    total++; if (last_src !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", last_src); end
    total++; if ({alu_ready, mem_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {alu_ready, mem_ready}); end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", {alu_ready, mem_ready}); end
    tick();
    alu_valid = 1'b0;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", rf_we); end
    total++; if (rf_rd !== 5'd5) begin bad++; $display("FAIL single_rd got=%0d exp=5", rf_rd); end
    total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h exp=deadbeef", rf_wdata); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL idle_we got=%b exp=0", rf_we); end
    total++; if (rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_hold got=%0d/%h exp=5/deadbeef", rf_rd, rf_wdata); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic       exp_last [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    idle_inputs();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h2222_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if ({alu_ready, mem_ready} !== exp_gnt[i]) begin bad++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, {alu_ready, mem_ready}, exp_gnt[i]); end
      tick();
      total++; if (last_src !== exp_last[i]) begin bad++; $display("FAIL b2b_last[%0d] got=%b exp=%b", i, last_src, exp_last[i]); end
      total++; if (rf_rd !== (exp_last[i] ? 5'd2 : 5'd1) || rf_we !== 1'b1) begin bad++; $display("FAIL b2b_write[%0d] got rd=%0d we=%b", i, rf_rd, rf_we); end
    end
    idle_inputs();
  endtask

  task automatic test_rd_zero();
    // pointer is ALU after the back-to-back run ended on a MEM grant
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_1234;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b01) begin bad++; $display("FAIL rd0_ready got=%b exp=01", {alu_ready, mem_ready}); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rd0_we got=%b exp=0", rf_we); end
    total++; if (last_src !== 1'b1) begin bad++; $display("FAIL rd0_last got=%b exp=1", last_src); end
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333_3333;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b10) begin bad++; $display("FAIL rd0_ptr got=%b exp=10", {alu_ready, mem_ready}); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h8888_8888;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9999_9999;
    flush = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if ({alu_ready, mem_ready} !== 2'b00) begin bad++; $display("FAIL flush_ready[%0d] got=%b exp=00", i, {alu_ready, mem_ready}); end
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL flush_we[%0d] got=%b exp=0", i, rf_we); end
    end
    flush = 1'b0;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b10) begin bad++; $display("FAIL flush_after got=%b exp=10", {alu_ready, mem_ready}); end
    tick();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd8) begin bad++; $display("FAIL flush_write got we=%b rd=%0d exp 1/8", rf_we, rf_rd); end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_7777;
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hC0DE_0003;
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd7) begin bad++; $display("FAIL mid_pre got we=%b rd=%0d exp 1/7", rf_we, rf_rd); end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL mid_we got=%b exp=0", rf_we); end
    total++; if ({alu_ready, mem_ready} !== 2'b00) begin bad++; $display("FAIL mid_ready got=%b exp=00", {alu_ready, mem_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b01) begin bad++; $display("FAIL mid_release got=%b exp=01", {alu_ready, mem_ready}); end
    tick();
    total++; if (rf_we !== 1'b1 || rf_rd !== 5'd3 || last_src !== 1'b1) begin bad++; $display("FAIL mid_grant got we=%b rd=%0d last=%b", rf_we, rf_rd, last_src); end
    idle_inputs();
    tick();
  endtask

`ifdef REGARB_BYPASS_EN
  task automatic test_forward();
    idle_inputs();
    tick();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA5A5A5A5;
    tick();
    alu_valid = 1'b0;
    fwd_rs1 = 5'd9; fwd_rs2 = 5'd0;
    #1;
    total++; if (fwd1_hit !== 1'b1 || fwd1_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL fwd1 got hit=%b data=%h", fwd1_hit, fwd1_data); end
    total++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'd0) begin bad++; $display("FAIL fwd2 got hit=%b data=%h", fwd2_hit, fwd2_data); end
    tick();
    total++; if (fwd1_hit !== 1'b0) begin bad++; $display("FAIL fwd1_stale got=%b exp=0", fwd1_hit); end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic ea, em;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      // held requests keep rd/data stable; otherwise draw new ones
      if (!(alu_valid && !m_acc_alu)) begin
        alu_valid = ($urandom_range(0, 99) < 65);
        alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_data = $urandom;
      end
      if (!(mem_valid && !m_acc_mem)) begin
        mem_valid = ($urandom_range(0, 99) < 65);
        mem_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mem_data = $urandom;
      end
      flush = ($urandom_range(0, 9) == 0);
`ifdef REGARB_BYPASS_EN
      fwd_rs1 = 5'($urandom_range(0, 31));
      fwd_rs2 = m_rd;
`endif
      #1;
      exp_ready(ea, em);
      total++; if ({alu_ready, mem_ready} !== {ea, em}) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, {alu_ready, mem_ready}, {ea, em}); end
`ifdef REGARB_BYPASS_EN
      total++; if (fwd2_hit !== (m_we && m_rd != 5'd0) || fwd2_data !== ((m_we && m_rd != 5'd0) ? m_data : 32'd0)) begin bad++; $display("FAIL rnd_fwd[%0d] got hit=%b data=%h", i, fwd2_hit, fwd2_data); end
`endif
      m_acc_alu = 1'b0; m_acc_mem = 1'b0;
      tick();
      total++; if (rf_we !== m_we) begin bad++; $display("FAIL rnd_we[%0d] got=%b exp=%b", i, rf_we, m_we); end
      total++; if (rf_rd !== m_rd || rf_wdata !== m_data) begin bad++; $display("FAIL rnd_port[%0d] got=%0d/%h exp=%0d/%h", i, rf_rd, rf_wdata, m_rd, m_data); end
      total++; if (last_src !== m_last) begin bad++; $display("FAIL rnd_last[%0d] got=%b exp=%b", i, last_src, m_last); end
    end
    idle_inputs();
  endtask

  initial begin
    m_acc_alu = 1'b0; m_acc_mem = 1'b0;
    test_reset();
    test_single_alu();
    test_back_to_back();
    test_rd_zero();
    test_flush();
    test_reset_midstream();
`ifdef REGARB_BYPASS_EN
    test_forward();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
